// File: rtl/shield_write_line_sched.sv
// Write-path scheduler: splits one AXI AW burst into per-cache-line jobs for the write slave
// and returns the B response once every issued line has been committed downstream.
module shield_write_line_sched #(
    parameter int CL_ID_WIDTH         = 6,
    parameter int CL_ADDR_WIDTH       = 64,
    parameter int CL_DATA_WIDTH       = 64,
    parameter int OFFSET_WIDTH        = 6,
    parameter int BURSTS_PER_LINE     = 8,
    parameter int BURSTS_PER_LINE_LOG = 3,
    parameter int MAX_OUTSTANDING     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CL_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [CL_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]               s_axi_awlen,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    output logic [CL_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    output logic [7:0]               burst_count,
    output logic [OFFSET_WIDTH-1:0]  burst_start_offset,
    output logic [CL_ADDR_WIDTH-1:0] line_addr,
    output logic                     req_val,
    input  logic                     req_rdy,
    input  logic                     line_done,
    output logic                     busy
);

    localparam int BEAT_LOG = $clog2(CL_DATA_WIDTH / 8);
    localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]         MAX_OUT    = OUT_W'(MAX_OUTSTANDING);
    localparam logic [8:0]               BPL        = 9'(BURSTS_PER_LINE);
    localparam logic [CL_ADDR_WIDTH-1:0] LINE_BYTES = CL_ADDR_WIDTH'(1) << OFFSET_WIDTH;
    localparam logic [CL_ADDR_WIDTH-1:0] BEAT_MASK  = (CL_ADDR_WIDTH'(1) << BEAT_LOG) - CL_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } state_t;

    state_t                   r_state;
    logic [CL_ID_WIDTH-1:0]   r_id;
    logic [CL_ADDR_WIDTH-1:0] r_addr;
    logic [8:0]               r_beatsRem;
    logic [OUT_W-1:0]         r_outstanding;
    logic                     r_awready;
    logic                     r_bvalid;
    logic                     r_reqVal;

    logic [BURSTS_PER_LINE_LOG-1:0] w_startIdx;
    logic [8:0]                     w_avail;
    logic [8:0]                     w_count;
    logic [8:0]                     w_beatsNext;
    logic [CL_ADDR_WIDTH-1:0]       w_lineAddr;
    logic [CL_ADDR_WIDTH-1:0]       w_nextLine;
    logic [CL_ADDR_WIDTH-1:0]       w_awAddr;
    logic                           w_awAccept;
    logic                           w_issue;
    logic                           w_retire;
    logic [OUT_W-1:0]               w_outNext;

    assign w_startIdx  = r_addr[OFFSET_WIDTH-1 -: BURSTS_PER_LINE_LOG];
    assign w_avail     = BPL - 9'(w_startIdx);
    assign w_count     = (r_beatsRem < w_avail) ? r_beatsRem : w_avail;
    assign w_beatsNext = r_beatsRem - w_count;
    assign w_lineAddr  = {r_addr[CL_ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    assign w_nextLine  = w_lineAddr + LINE_BYTES;
    assign w_awAddr    = s_axi_awaddr & ~BEAT_MASK;
    assign w_awAccept  = s_axi_awvalid & r_awready;
    assign w_issue     = r_reqVal & req_rdy;
    // A commit pulse with nothing outstanding is stale and must not underflow the counter.
    assign w_retire    = line_done & (r_outstanding != '0);

    always_comb begin
        w_outNext = r_outstanding;
        if (w_issue && !w_retire) begin
            w_outNext = r_outstanding + OUT_W'(1);
        end else if (!w_issue && w_retire) begin
            w_outNext = r_outstanding - OUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_id          <= '0;
            r_addr        <= '0;
            r_beatsRem    <= '0;
            r_outstanding <= '0;
            r_awready     <= 1'b1;
            r_bvalid      <= 1'b0;
            r_reqVal      <= 1'b0;
        end else begin
            r_outstanding <= w_outNext;
            case (r_state)
                IDLE: begin
                    if (w_awAccept) begin
                        r_id       <= s_axi_awid;
                        r_addr     <= w_awAddr;
                        r_beatsRem <= {1'b0, s_axi_awlen} + 9'd1;
                        r_awready  <= 1'b0;
                        r_reqVal   <= (w_outNext < MAX_OUT);
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // req_val is recomputed from the next occupancy so it only rises when a slot frees.
                    if (w_issue) begin
                        r_beatsRem <= w_beatsNext;
                        r_addr     <= w_nextLine;
                        if (w_beatsNext == 9'd0) begin
                            r_reqVal <= 1'b0;
                            r_state  <= DRAIN;
                        end else begin
                            r_reqVal <= (w_outNext < MAX_OUT);
                        end
                    end else begin
                        r_reqVal <= (w_outNext < MAX_OUT);
                    end
                end
                DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_bvalid <= 1'b1;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_axi_awready      = r_awready;
    assign s_axi_bvalid       = r_bvalid;
    assign s_axi_bid          = r_id;
    assign s_axi_bresp        = 2'b00;
    assign req_val            = r_reqVal;
    assign burst_count        = w_count[7:0];
    assign burst_start_offset = r_addr[OFFSET_WIDTH-1:0];
    assign line_addr          = w_lineAddr;
    assign busy               = (r_state != IDLE);

endmodule

// File: tb/tb_shield_write_line_sched.sv
// Self-checking bench for shield_write_line_sched: expected line jobs and B responses are queued
// when an AW is driven and compared as the DUT hands them over.
module tb_shield_write_line_sched;

    localparam int MAXO = 2;

    typedef struct packed {
        logic [7:0]  cnt;
        logic [5:0]  off;
        logic [63:0] line;
    } job_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  s_axi_awid;
    logic [63:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [5:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [7:0]  burst_count;
    logic [5:0]  burst_start_offset;
    logic [63:0] line_addr;
    logic        req_val;
    logic        req_rdy;
    logic        line_done;
    logic        busy;

    job_t       expJobs[$];
    logic [5:0] expB[$];
    int         pendDone[$];
    int         checks;
    int         errors;
    int         cycle;
    int         mOut;
    int         maxOut;
    int         jobsSeen;
    int         bSeen;
    int         doneDelay;
    bit         autoDone;
    bit         manualDone;

    shield_write_line_sched #(
        .CL_ID_WIDTH        (6),
        .CL_ADDR_WIDTH      (64),
        .CL_DATA_WIDTH      (64),
        .OFFSET_WIDTH       (6),
        .BURSTS_PER_LINE    (8),
        .BURSTS_PER_LINE_LOG(3),
        .MAX_OUTSTANDING    (MAXO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axi_awid        (s_axi_awid),
        .s_axi_awaddr      (s_axi_awaddr),
        .s_axi_awlen       (s_axi_awlen),
        .s_axi_awvalid     (s_axi_awvalid),
        .s_axi_awready     (s_axi_awready),
        .s_axi_bid         (s_axi_bid),
        .s_axi_bresp       (s_axi_bresp),
        .s_axi_bvalid      (s_axi_bvalid),
        .s_axi_bready      (s_axi_bready),
        .burst_count       (burst_count),
        .burst_start_offset(burst_start_offset),
        .line_addr         (line_addr),
        .req_val           (req_val),
        .req_rdy           (req_rdy),
        .line_done         (line_done),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: observe handshakes on the falling edge, then advance and drive the commit model.
    task automatic tick();
        bit   hs;
        bit   ld;
        bit   autoPulse;
        job_t e;
        @(negedge clk);
        if (rst_n) begin
            hs = req_val && req_rdy;
            ld = line_done;
            if (mOut == MAXO) begin
                checks++;
                if (req_val) begin
                    errors++;
                    $display("[TB] FAIL outstanding_limit: req_val=%0b with %0d outstanding, required 0", req_val, mOut);
                end
            end
            if (hs) begin
                checks++;
                if (expJobs.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_job: cnt=%0d off=%0h line=%0h, required no job", burst_count, burst_start_offset, line_addr);
                end else begin
                    e = expJobs.pop_front();
                    if (burst_count !== e.cnt || burst_start_offset !== e.off || line_addr !== e.line) begin
                        errors++;
                        $display("[TB] FAIL job: got cnt=%0d off=%0h line=%0h, required cnt=%0d off=%0h line=%0h",
                                 burst_count, burst_start_offset, line_addr, e.cnt, e.off, e.line);
                    end
                end
                jobsSeen++;
                if (autoDone) pendDone.push_back(cycle + doneDelay);
            end
            if (hs && !(ld && mOut > 0)) mOut++;
            else if (!hs && ld && mOut > 0) mOut--;
            if (mOut > maxOut) maxOut = mOut;
            if (s_axi_bvalid && s_axi_bready) begin
                checks++;
                if (expB.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_b: bid=%0h, required no response", s_axi_bid);
                end else begin
                    automatic logic [5:0] id = expB.pop_front();
                    if (s_axi_bid !== id || s_axi_bresp !== 2'b00) begin
                        errors++;
                        $display("[TB] FAIL b_resp: got bid=%0h bresp=%0b, required bid=%0h bresp=0", s_axi_bid, s_axi_bresp, id);
                    end
                end
                bSeen++;
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        autoPulse = 1'b0;
        if (pendDone.size() > 0 && pendDone[0] <= cycle) begin
            autoPulse = 1'b1;
            void'(pendDone.pop_front());
        end
        line_done = manualDone || autoPulse;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pushJob(input logic [7:0] cnt, input logic [5:0] off, input logic [63:0] line);
        job_t j;
        j.cnt  = cnt;
        j.off  = off;
        j.line = line;
        expJobs.push_back(j);
    endtask

    task automatic sendAw(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
        bit ok;
        ok = 1'b0;
        expB.push_back(id);
        s_axi_awid    = id;
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (s_axi_awready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        s_axi_awvalid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL aw_timeout: awready never seen for addr=%0h", addr);
        end
    endtask

    task automatic waitB(input int budget);
        int start;
        int n;
        start = bSeen;
        n = 0;
        while (bSeen == start && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (bSeen == start) begin
            errors++;
            $display("[TB] FAIL b_timeout: no B response within %0d cycles, required one", budget);
        end
    endtask

    task automatic waitJobs(input int target, input int budget);
        int n;
        n = 0;
        while (jobsSeen < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (jobsSeen < target) begin
            errors++;
            $display("[TB] FAIL job_timeout: saw %0d jobs, required %0d", jobsSeen, target);
        end
    endtask

    task automatic pulseDone();
        manualDone = 1'b1;
        tick();
        manualDone = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        tick();
        checks++;
        if (s_axi_awready !== 1'b1 || s_axi_bvalid !== 1'b0 || req_val !== 1'b0 || busy !== 1'b0 || s_axi_bresp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_state: awready=%0b bvalid=%0b req_val=%0b busy=%0b bresp=%0b, required 1 0 0 0 0",
                     s_axi_awready, s_axi_bvalid, req_val, busy, s_axi_bresp);
        end
    endtask

    task automatic test_single_line();
        int j0;
        int n;
        j0 = jobsSeen;
        autoDone = 1'b1;
        doneDelay = 2;
        s_axi_bready = 1'b0;
        pushJob(8'd8, 6'h00, 64'h1000);
        sendAw(6'h05, 64'h1000, 8'd7);
        n = 0;
        while (!s_axi_bvalid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bid !== 6'h05) begin
            errors++;
            $display("[TB] FAIL single_bvalid: bvalid=%0b bid=%0h, required 1 05", s_axi_bvalid, s_axi_bid);
        end
        ticks(3);
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b_hold: bvalid=%0b awready=%0b, required 1 0", s_axi_bvalid, s_axi_awready);
        end
        s_axi_bready = 1'b1;
        waitB(20);
        checks++;
        if (s_axi_awready !== 1'b1 || busy !== 1'b0 || jobsSeen - j0 != 1) begin
            errors++;
            $display("[TB] FAIL single_done: awready=%0b busy=%0b jobs=%0d, required 1 0 1", s_axi_awready, busy, jobsSeen - j0);
        end
    endtask

    task automatic test_split();
        int j0;
        j0 = jobsSeen;
        autoDone = 1'b0;
        pushJob(8'd2, 6'h30, 64'h1000);
        pushJob(8'd6, 6'h00, 64'h1040);
        sendAw(6'h11, 64'h1030, 8'd7);
        waitJobs(j0 + 2, 20);
        ticks(3);
        checks++;
        if (s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL split_early_b0: bvalid=%0b with 2 lines outstanding, required 0", s_axi_bvalid);
        end
        pulseDone();
        ticks(3);
        checks++;
        if (s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL split_early_b1: bvalid=%0b with 1 line outstanding, required 0", s_axi_bvalid);
        end
        pulseDone();
        waitB(20);
    endtask

    task automatic test_low_bits();
        int j0;
        autoDone = 1'b1;
        doneDelay = 3;
        j0 = jobsSeen;
        pushJob(8'd1, 6'h38, 64'h1000);
        sendAw(6'h21, 64'h1038, 8'd0);
        waitB(30);
        pushJob(8'd1, 6'h38, 64'h1000);
        sendAw(6'h22, 64'h103C, 8'd0);
        waitB(30);
        checks++;
        if (jobsSeen - j0 != 2 || expJobs.size() != 0) begin
            errors++;
            $display("[TB] FAIL low_bits_jobs: jobs=%0d left=%0d, required 2 0", jobsSeen - j0, expJobs.size());
        end
    endtask

    task automatic test_long_burst();
        int j0;
        int b0;
        autoDone = 1'b1;
        doneDelay = 10;
        maxOut = 0;
        j0 = jobsSeen;
        for (int i = 0; i < 32; i++) pushJob(8'd8, 6'h00, 64'(i) * 64'd64);
        sendAw(6'h2A, 64'h0, 8'd255);
        b0 = bSeen;
        waitB(2000);
        ticks(5);
        checks++;
        if (jobsSeen - j0 != 32 || bSeen - b0 != 1) begin
            errors++;
            $display("[TB] FAIL long_counts: jobs=%0d b=%0d, required 32 1", jobsSeen - j0, bSeen - b0);
        end
        checks++;
        if (maxOut != MAXO) begin
            errors++;
            $display("[TB] FAIL long_occupancy: peak outstanding %0d, required %0d", maxOut, MAXO);
        end
    endtask

    task automatic test_stall_coincide();
        int j0;
        autoDone = 1'b0;
        req_rdy = 1'b0;
        pushJob(8'd8, 6'h00, 64'h2000);
        pushJob(8'd8, 6'h00, 64'h2040);
        sendAw(6'h33, 64'h2000, 8'd15);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (req_val !== 1'b1 || burst_count !== 8'd8 || burst_start_offset !== 6'h00 || line_addr !== 64'h2000) begin
                errors++;
                $display("[TB] FAIL stall_stable: req_val=%0b cnt=%0d off=%0h line=%0h, required 1 8 0 2000",
                         req_val, burst_count, burst_start_offset, line_addr);
            end
            tick();
        end
        req_rdy = 1'b1;
        tick();
        req_rdy = 1'b0;
        manualDone = 1'b1;
        tick();
        req_rdy = 1'b1;
        manualDone = 1'b0;
        tick();
        ticks(4);
        checks++;
        if (s_axi_bvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL coincide: bvalid=%0b busy=%0b, required 0 1 (one line still outstanding)", s_axi_bvalid, busy);
        end
        pulseDone();
        waitB(20);
        pulseDone();
        checks++;
        if (s_axi_awready !== 1'b1 || busy !== 1'b0 || s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spurious_idle: awready=%0b busy=%0b bvalid=%0b, required 1 0 0", s_axi_awready, busy, s_axi_bvalid);
        end
        j0 = jobsSeen;
        pushJob(8'd8, 6'h00, 64'h3000);
        sendAw(6'h34, 64'h3000, 8'd7);
        waitJobs(j0 + 1, 20);
        ticks(3);
        checks++;
        if (s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_spurious: bvalid=%0b before line_done, required 0", s_axi_bvalid);
        end
        pulseDone();
        waitB(20);
    endtask

    task automatic test_reset_mid();
        int b0;
        autoDone = 1'b0;
        req_rdy = 1'b0;
        pushJob(8'd8, 6'h00, 64'h4000);
        pushJob(8'd8, 6'h00, 64'h4040);
        pushJob(8'd8, 6'h00, 64'h4080);
        sendAw(6'h3F, 64'h4000, 8'd23);
        req_rdy = 1'b1;
        tick();
        req_rdy = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (s_axi_awready !== 1'b1 || req_val !== 1'b0 || s_axi_bvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: awready=%0b req_val=%0b bvalid=%0b busy=%0b, required 1 0 0 0",
                     s_axi_awready, req_val, s_axi_bvalid, busy);
        end
        expJobs.delete();
        expB.delete();
        pendDone.delete();
        mOut = 0;
        b0 = bSeen;
        ticks(3);
        req_rdy = 1'b1;
        autoDone = 1'b1;
        doneDelay = 2;
        pushJob(8'd4, 6'h10, 64'h4000);
        sendAw(6'h3E, 64'h4010, 8'd3);
        waitB(30);
        checks++;
        if (bSeen - b0 != 1 || expJobs.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_recover: b=%0d jobs_left=%0d, required 1 0", bSeen - b0, expJobs.size());
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cycle         = 0;
        mOut          = 0;
        maxOut        = 0;
        jobsSeen      = 0;
        bSeen         = 0;
        doneDelay     = 2;
        autoDone      = 1'b0;
        manualDone    = 1'b0;
        rst_n         = 1'b0;
        s_axi_awid    = '0;
        s_axi_awaddr  = '0;
        s_axi_awlen   = '0;
        s_axi_awvalid = 1'b0;
        s_axi_bready  = 1'b1;
        req_rdy       = 1'b1;
        line_done     = 1'b0;

        $display("[TB] starting");
        test_reset();
        test_single_line();
        test_split();
        test_low_bits();
        test_long_burst();
        test_stall_coincide();
        test_reset_mid();
        ticks(5);
        checks++;
        if (expJobs.size() != 0 || expB.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover: jobs=%0d b=%0d still expected, required 0 0", expJobs.size(), expB.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
